// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM level meter and its input synchronizer.
package pwm_pkg;

  typedef enum logic {
    ACQ = 1'b0,
    RUN = 1'b1
  } meter_state_e;

  localparam int unsigned DEF_LEVEL_BITS = 8;

  // Window counter width: one PWM period times the number of averaged periods.
  function automatic int unsigned win_bits(input int unsigned level_bits,
                                           input int unsigned avg_log2);
    return level_bits + avg_log2;
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for an asynchronous PWM input, cleared by synchronous reset.
module pwm_in_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_level_meter.sv
// Recovers the duty level of a free-running PWM waveform once per window and flags
// upward jumps and loss of modulation. Define PWM_METER_SYNC_EN to add a 2-flop input synchronizer.
module pwm_level_meter
  import pwm_pkg::*;
#(
  parameter int unsigned LEVEL_BITS = DEF_LEVEL_BITS,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned JUMP_MIN   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm_in,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_valid,
  output logic                  sat,
  output logic                  trig,
  output logic                  active
);

  localparam int unsigned W = win_bits(LEVEL_BITS, AVG_LOG2);
  localparam logic [W:0] FULL_SCALE = (W+1)'(1) << LEVEL_BITS;
  localparam logic [LEVEL_BITS:0] JUMP_THR = (LEVEL_BITS+1)'(JUMP_MIN);

  logic sample;

`ifdef PWM_METER_SYNC_EN
  pwm_in_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pwm_in),
    .q_o   (sample)
  );
`else
  assign sample = pwm_in;
`endif

  // A full-high window counts 2**LEVEL_BITS, one past the largest representable level.
  function automatic logic [LEVEL_BITS-1:0] clip_level(input logic [W:0] q);
    if (q >= FULL_SCALE) begin
      return '1;
    end
    return q[LEVEL_BITS-1:0];
  endfunction

  function automatic logic is_full(input logic [W:0] q);
    return (q >= FULL_SCALE);
  endfunction

  meter_state_e          state_q;
  logic [W-1:0]          wcnt_q, wcnt_d;
  logic [W:0]            hcnt_q, hcnt_d;
  logic                  edge_q, edge_d;
  logic                  prev_q;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic                  sat_q, sat_d;
  logic                  active_q, active_d;
  logic                  valid_q;
  logic                  trig_q;

  logic                  win_end;
  logic                  edge_now;
  logic [W:0]            hsum;
  logic [W:0]            q_avg;
  logic                  jump;

  always_comb begin
    win_end  = &wcnt_q;
    edge_now = sample ^ prev_q;
    hsum     = hcnt_q + (W+1)'(sample);
    q_avg    = hsum >> AVG_LOG2;

    wcnt_d   = wcnt_q + W'(1);
    hcnt_d   = hsum;
    edge_d   = edge_q | edge_now;
    level_d  = level_q;
    sat_d    = sat_q;
    active_d = active_q;
    jump     = 1'b0;

    // Last sample of the window folds straight into the result; counters restart with no gap.
    if (win_end) begin
      hcnt_d   = '0;
      edge_d   = 1'b0;
      level_d  = clip_level(q_avg);
      sat_d    = is_full(q_avg);
      active_d = edge_q | edge_now;
      jump     = (state_q == RUN) &&
                 ({1'b0, level_d} > ({1'b0, level_q} + JUMP_THR));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACQ;
      wcnt_q   <= '0;
      hcnt_q   <= '0;
      edge_q   <= 1'b0;
      prev_q   <= 1'b0;
      level_q  <= '0;
      sat_q    <= 1'b0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      hcnt_q   <= hcnt_d;
      edge_q   <= edge_d;
      prev_q   <= sample;
      level_q  <= level_d;
      sat_q    <= sat_d;
      active_q <= active_d;
      valid_q  <= win_end;
      trig_q   <= jump;
      case (state_q)
        ACQ:     if (win_end) state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= ACQ;
      endcase
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q;
  assign sat         = sat_q;
  assign trig        = trig_q;
  assign active      = active_q;

endmodule

// File: tb/tb_pwm_level_meter.sv
// Scoreboard bench for pwm_level_meter: a generator drives pwm_in and predicts each window result.
module tb_pwm_level_meter;

  localparam int WIN  = 256;
  localparam int JMP  = 16;
  localparam int AWIN = 1024;

  typedef struct {
    logic [7:0] lvl;
    logic       sat;
    logic       act;
    logic       trg;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] level, a_level;
  logic       level_valid, sat, trig, active;
  logic       a_valid, a_sat, a_trig, a_active;

  pwm_level_meter #(.LEVEL_BITS(8), .AVG_LOG2(0), .JUMP_MIN(JMP)) u_dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .level(level), .level_valid(level_valid),
    .sat(sat), .trig(trig), .active(active)
  );

  pwm_level_meter #(.LEVEL_BITS(8), .AVG_LOG2(2), .JUMP_MIN(JMP)) u_avg (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .level(a_level), .level_valid(a_valid),
    .sat(a_sat), .trig(a_trig), .active(a_active)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t e_pop, e_push;

  int         abs_cyc = 0;
  int         m_cyc = 0;
  int         m_hi = 0;
  int         m_plvl = 0;
  int         q_mod;
  logic       m_edge = 1'b0, m_prev = 1'b0, m_run = 1'b0;
  logic [1:0] hist = 2'b00;
  logic       v_drv, s_mod;
  logic [7:0] gen_cnt = 8'd37;
  logic       alt = 1'b0;
  int         pwm_mode = 2;
  int         L = 128;
  int         trig_cnt = 0;
  bit         avg_on = 1'b0;
  int         a_last = 0;
  int         a_nvalid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  // Compare outputs of the current cycle, then drive and model the next sample.
  always @(negedge clk) begin
    if (level_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(level_valid), 32'd0);
      end else begin
        e_pop = sb.pop_front();
        check("level", 32'(level), 32'(e_pop.lvl));
        check("sat", 32'(sat), 32'(e_pop.sat));
        check("active", 32'(active), 32'(e_pop.act));
        check("trig", 32'(trig), 32'(e_pop.trg));
        check("valid_cycle", 32'(abs_cyc), 32'(e_pop.cyc));
      end
      if (trig) trig_cnt++;
    end else if (sb.size() > 0 && sb[0].cyc < abs_cyc) begin
      check("missing_valid", 32'(abs_cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (trig && !level_valid) check("trig_without_valid", 32'(trig), 32'd0);

    if (avg_on && a_valid) begin
      if (a_nvalid > 0) begin
        check("avg_level", 32'(a_level), 32'd128);
        check("avg_sat", 32'(a_sat), 32'd0);
        check("avg_active", 32'(a_active), 32'd1);
      end
      check("avg_interval", 32'(abs_cyc - a_last), 32'(AWIN));
      a_last = abs_cyc;
      a_nvalid++;
    end

    case (pwm_mode)
      0:       v_drv = 1'b0;
      1:       v_drv = 1'b1;
      3:       v_drv = (gen_cnt < (alt ? 8'd192 : 8'd64));
      default: v_drv = (32'(gen_cnt) < L);
    endcase
    pwm_in = v_drv;
    if (gen_cnt == 8'd255) alt = ~alt;
    gen_cnt = gen_cnt + 8'd1;

    if (reset) begin
      m_cyc = 0; m_hi = 0; m_edge = 1'b0; m_prev = 1'b0;
      m_run = 1'b0; m_plvl = 0; hist = 2'b00;
      sb.delete();
      a_last = abs_cyc + 1;
    end else begin
`ifdef PWM_METER_SYNC_EN
      s_mod = hist[1];
      hist  = {hist[0], v_drv};
`else
      s_mod = v_drv;
`endif
      m_hi   = m_hi + int'(s_mod);
      m_edge = m_edge | (s_mod != m_prev);
      m_prev = s_mod;
      if ((m_cyc % WIN) == WIN - 1) begin
        q_mod      = m_hi;
        e_push.sat = (q_mod >= 256);
        e_push.lvl = e_push.sat ? 8'hFF : q_mod[7:0];
        e_push.act = m_edge;
        e_push.trg = m_run && (int'(e_push.lvl) > m_plvl + JMP);
        e_push.cyc = abs_cyc + 1;
        sb.push_back(e_push);
        m_plvl = int'(e_push.lvl);
        m_run  = 1'b1;
        m_hi   = 0;
        m_edge = 1'b0;
      end
      m_cyc++;
    end
    abs_cyc++;
  end

  initial begin
    cycles(3);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(level_valid), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_avg_valid", 32'(a_valid), 32'd0);
    reset = 1'b0;

    // L=128 at arbitrary generator phase
    cycles(256);
    check("first_valid_at_256", 32'(level_valid), 32'd1);
    check("first_trig_acq", 32'(trig), 32'd0);
    cycles(256);
    check("l128_level", 32'(level), 32'd128);
    check("l128_active", 32'(active), 32'd1);
    check("l128_sat", 32'(sat), 32'd0);

    pwm_mode = 1;
    cycles(512);
    check("high_valid", 32'(level_valid), 32'd1);
    check("high_level", 32'(level), 32'd255);
    check("high_sat", 32'(sat), 32'd1);
    check("high_active", 32'(active), 32'd0);

    pwm_mode = 0;
    cycles(768);
    check("low_level", 32'(level), 32'd0);
    check("low_sat", 32'(sat), 32'd0);
    check("low_active", 32'(active), 32'd0);

    // Step up 10 -> 200, then back down
    pwm_mode = 2;
    L = 10;
    cycles(768);
    trig_cnt = 0;
    L = 200;
    cycles(256);
    check("step_valid", 32'(level_valid), 32'd1);
    check("step_trig", 32'(trig), 32'd1);
    cycles(512);
    check("step_trig_once", 32'(trig_cnt), 32'd1);
    check("step_level", 32'(level), 32'd200);
    L = 10;
    cycles(768);
    check("stepdown_no_trig", 32'(trig_cnt), 32'd1);
    check("stepdown_level", 32'(level), 32'd10);

    // Fade down one step per window, changes landing mid-window
    L = 60;
    cycles(512);
    trig_cnt = 0;
    cycles(100);
    for (int i = 1; i <= 10; i++) begin
      L = 60 - i;
      cycles(256);
    end
    cycles(256);
    check("fade_no_trig", 32'(trig_cnt), 32'd0);
    check("fade_level", 32'(level), 32'd50);

    // Reset for one cycle at wcnt=100
    L = 200;
    cycles(512);
    for (int i = 0; i < 300 && (m_cyc % WIN) != 100; i++) cycles(1);
    check("midwin_reach", 32'(m_cyc % WIN), 32'd100);
    pulse_reset();
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(level_valid), 32'd0);
    check("midrst_sat", 32'(sat), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_trig", 32'(trig), 32'd0);
    cycles(256);
    check("midrst_valid_256", 32'(level_valid), 32'd1);
    check("midrst_trig_acq", 32'(trig), 32'd0);
    cycles(256);
    check("midrst_level_after", 32'(level), 32'd200);

    // Alternating 64/192 per period, averaged over four periods by u_avg
    pwm_mode = 3;
    avg_on = 1'b1;
    pulse_reset();
    cycles(4 * AWIN + 8);
    check("avg_valid_count", 32'(a_nvalid), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
